// File: rtl/freq_div_prog.sv
// rtl/freq_div_prog.sv - programmable integer clock divider with glitch-free divisor reload
module freq_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] staged_q, staged_d;
  logic             pend_q, pend_d;

  logic [WIDTH:0]   high_len;
  logic [WIDTH:0]   cnt_inc;
  logic             period_start;

  // High phase is ceil(N/2); kept one bit wider so N=2^WIDTH-1 cannot wrap.
  assign high_len = {1'b0, div_cur_q} - {2'b00, div_cur_q[WIDTH-1:1]};
  assign cnt_inc  = {1'b0, cnt_q} + {1'b0, ONE};

  always_comb begin
    cnt_d        = cnt_q;
    run_d        = run_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    cfg_err_d    = 1'b0;
    div_cur_d    = div_cur_q;
    staged_d     = staged_q;
    pend_d       = pend_q;
    period_start = 1'b0;

    if (!en) begin
      run_d     = 1'b0;
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (!run_q || (cnt_q == div_cur_q - ONE)) begin
      period_start = 1'b1;
      run_d        = 1'b1;
      cnt_d        = '0;
      clk_out_d    = 1'b1;
      tick_d       = 1'b1;
    end else begin
      cnt_d     = cnt_inc[WIDTH-1:0];
      clk_out_d = (cnt_inc < high_len);
    end

    // The boundary consumes the value staged before this edge; a load on the
    // same edge is staged afterwards for the following boundary.
    if (period_start && pend_q) begin
      div_cur_d = staged_q;
      pend_d    = 1'b0;
    end

    if (div_load) begin
      if (div_val >= MIN_DIV) begin
        staged_d = div_val;
        pend_d   = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      run_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      div_cur_q <= DIV_RST;
      staged_q  <= DIV_RST;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
      div_cur_q <= div_cur_d;
      staged_q  <= staged_d;
      pend_q    <= pend_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_cur = div_cur_q;
  assign pend    = pend_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
- Programmable integer clock divider; generalises the fixed divide-by-4 block to any divisor N in 2..2^WIDTH-1, even or odd.
- Runtime divisor changes take effect glitch-free, only at a period boundary.
- Produces a registered divided clock plus a one-cycle tick at each divided-clock rising edge, for use as a clock-enable.
- Sits between the system clock and slow peripherals (baud, PWM, LED timers) in the same clock domain.

Parameters:
- WIDTH, 8, width of divisor and internal counter.
- DEFAULT_DIV, 4, divisor in effect after reset; legal range 2..2^WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low stops and parks the output.
- div_load  input  1  one-cycle request to stage div_val as the next divisor.
- div_val  input  WIDTH  requested divisor, sampled when div_load=1.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, high in the same cycle clk_out goes 0->1.
- div_cur  output  WIDTH  divisor currently in effect.
- pend  output  1  a staged divisor awaits the next boundary.
- cfg_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, run=0.
  - clk_out=0, tick=0, cfg_err=0.
  - div_cur=DEFAULT_DIV, pend=0.
  - Staged register = DEFAULT_DIV.
- High time H = N - floor(N/2), i.e. ceil(N/2); low time = floor(N/2). For example:
  - N=4: 2 high, 2 low.
  - N=5: 3 high, 2 low.
  - Period is always exactly N clk cycles.
- Each posedge with en=1, run=0 (start):
  - run<=1, cnt<=0.
  - If pend, div_cur<=staged and pend<=0.
  - clk_out<=1, tick<=1.
  - Latency: clk_out rises on the first edge at which en is sampled high.
- Each posedge with en=1, run=1:
  - If cnt==div_cur-1 (boundary): cnt<=0; if pend, div_cur<=staged and pend<=0; clk_out<=1, tick<=1.
  - Otherwise: cnt<=cnt+1, clk_out<=(cnt+1 < H of div_cur), tick<=0.
- Each posedge with en=0:
  - run<=0, cnt<=0, clk_out<=0, tick<=0.
  - div_cur, staged value and pend are retained.
  - Stopping mid-period truncates that period; it is not completed.
- Load handling:
  - div_load=1 with div_val>=2: staged<=div_val, pend<=1.
  - A load while pend=1 overwrites the staged value (last wins).
  - div_load=1 with div_val<2: staged and pend unchanged, cfg_err<=1 for one cycle.
  - Loads are accepted whether en is high or low.
- Load on a boundary edge: the boundary applies the previously staged value, if any. The new div_val becomes staged with pend=1, for the following boundary.
- div_cur never changes except at a boundary or a start edge, so no period is ever shortened or stretched by a load.
- Arithmetic: cnt is WIDTH bits, unsigned. The comparison cnt+1 < H is computed at WIDTH+1 bits to avoid wrap at N=2^WIDTH-1.
- Reset asserted mid-period: outputs drop to reset values immediately, without waiting for clk.

Test Plan:
- Reset, en=1 held, DEFAULT_DIV=4 -> clk_out 1,1,0,0 repeating from the first enabled edge; tick every 4th cycle, aligned with each clk_out rise; div_cur=4.
- Load div_val=5 mid-period, then 7 before the boundary -> the current 4-cycle period completes unchanged, pend=1; the next period uses N=7 (4 high, 3 low); the value 5 is never applied.
- Load div_val=1, then div_val=0 -> cfg_err pulses once per attempt; div_cur and pend unchanged; output period unaffected.
- N=2 and N=255 (WIDTH=8) -> 1/1 and 128/127 high/low, period exactly N; no wrap glitch at cnt=254.
- Drop en for 3 cycles mid-high-phase with N=6 -> clk_out=0 and tick=0 on the next edge; re-raising en gives clk_out=1 and tick=1 on the first sampled edge, with a full 3/3 period following.
- Assert reset mid-period with pend=1 -> clk_out=0 immediately (asynchronous); div_cur=4, pend=0 after release.
